vec_op_sequencer: RTL and testbench

Issue controller between the instruction decoder and the vector datapath of the Vector ASIP. It accepts one decoded instruction at a time (5-bit opcode plus 25-bit immediate) and holds the active vector length set by SETN. It emits single-cycle pulses for scalar index ops. Each vector op (MULFV, SUMFV, LDV) is sequenced as a stream of lane-group beats to the datapath over a valid/ready handshake.

---
 rtl/vasip_pkg.sv | 29 ++
 rtl/vseq_lane_mask.sv | 26 ++
 rtl/vec_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_vec_op_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vasip_pkg.sv
// Vector ASIP shared definitions: datapath widths, opcode encodings,
// scalar-op pulse encoding and the issue FSM state type.
package vasip_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned IMM_W = 25;

  typedef enum logic [4:0] {
    OPC_INCRI = 5'b00000,
    OPC_INCRJ = 5'b00010,
    OPC_SETN  = 5'b00100,
    OPC_SUMFV = 5'b00110,
    OPC_MULFV = 5'b01001,
    OPC_NOP   = 5'b01010,
    OPC_LDV   = 5'b01101
  } opcode_e;

  typedef enum logic [1:0] {
    SCA_NONE  = 2'b00,
    SCA_INCRI = 2'b01,
    SCA_INCRJ = 2'b10
  } sca_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } vseq_state_e;

endpackage

// File: rtl/vseq_lane_mask.sv
// Lane-group mask generator.
// Converts the number of elements still to be issued into the active-lane
// mask of the current beat and flags whether this beat is the last one.
//   rem_i   : elements remaining, including the current beat
//   mask_o  : bit k set when element (base + k) is valid
//   last_o  : current beat covers all remaining elements
module vseq_lane_mask
  import vasip_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned IMM_W = vasip_pkg::IMM_W
) (
  input  logic [IMM_W-1:0] rem_i,
  output logic [LANES-1:0] mask_o,
  output logic             last_o
);

  always_comb begin
    mask_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      mask_o[k] = (rem_i > IMM_W'(k));
    end
    last_o = (rem_i <= IMM_W'(LANES));
  end

endmodule

// File: rtl/vec_op_sequencer.sv
// Vector op issue controller.
// Accepts one decoded instruction at a time, holds the vector length set by
// SETN, pulses scalar index ops, and streams each vector op (SUMFV, MULFV,
// LDV) to the datapath as LANES-wide beats over valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake; opcode, imm payload
//   sca_op_valid, sca_op       one-cycle scalar op pulse (01 INCRI, 10 INCRJ)
//   dp_valid/dp_ready          datapath beat handshake
//   dp_op, dp_base, dp_mask,
//   dp_last                    beat payload, zero outside ISSUE
//   vlen                       current vector length
//   err_illegal                one-cycle pulse on unknown opcode
//   perf_beats, perf_stalls    saturating counters, built only when
//                              VSEQ_PERF_CNT_EN is defined (else tied 0)
module vec_op_sequencer
  import vasip_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned IMM_W = vasip_pkg::IMM_W,
  parameter int unsigned OP_W  = vasip_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [IMM_W-1:0] imm,
  output logic             sca_op_valid,
  output logic [1:0]       sca_op,
  output logic             dp_valid,
  input  logic             dp_ready,
  output logic [OP_W-1:0]  dp_op,
  output logic [IMM_W-1:0] dp_base,
  output logic [LANES-1:0] dp_mask,
  output logic             dp_last,
  output logic [IMM_W-1:0] vlen,
  output logic             err_illegal,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stalls
);

  vseq_state_e      state_q, state_d;
  logic [IMM_W-1:0] vlen_q, vlen_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [IMM_W-1:0] base_q, base_d;
  logic [IMM_W-1:0] rem_q, rem_d;
  logic             sca_valid_q, sca_valid_d;
  sca_op_e          sca_op_q, sca_op_d;
  logic             err_q, err_d;

  logic [LANES-1:0] mask_raw;
  logic             last_raw;
  logic             issue;
  logic             beat_hs;

  vseq_lane_mask #(
    .LANES (LANES),
    .IMM_W (IMM_W)
  ) u_lane_mask (
    .rem_i  (rem_q),
    .mask_o (mask_raw),
    .last_o (last_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vlen_q      <= '0;
      op_q        <= '0;
      base_q      <= '0;
      rem_q       <= '0;
      sca_valid_q <= 1'b0;
      sca_op_q    <= SCA_NONE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vlen_q      <= vlen_d;
      op_q        <= op_d;
      base_q      <= base_d;
      rem_q       <= rem_d;
      sca_valid_q <= sca_valid_d;
      sca_op_q    <= sca_op_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vlen_d      = vlen_q;
    op_d        = op_q;
    base_d      = base_q;
    rem_d       = rem_q;
    sca_valid_d = 1'b0;
    sca_op_d    = SCA_NONE;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          case (opcode)
            OP_W'(OPC_INCRI): begin
              sca_valid_d = 1'b1;
              sca_op_d    = SCA_INCRI;
            end
            OP_W'(OPC_INCRJ): begin
              sca_valid_d = 1'b1;
              sca_op_d    = SCA_INCRJ;
            end
            OP_W'(OPC_SETN): vlen_d = imm;
            OP_W'(OPC_NOP):  ;
            OP_W'(OPC_SUMFV), OP_W'(OPC_MULFV), OP_W'(OPC_LDV): begin
              // Zero-length vector ops retire immediately without beats.
              if (vlen_q != '0) begin
                op_d    = opcode;
                base_d  = '0;
                rem_d   = vlen_q;
                state_d = ST_ISSUE;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_ISSUE: begin
        if (dp_ready) begin
          if (last_raw) begin
            state_d = ST_IDLE;
          end else begin
            base_d = base_q + IMM_W'(LANES);
            rem_d  = rem_q - IMM_W'(LANES);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue        = (state_q == ST_ISSUE);
  assign beat_hs      = issue && dp_ready;

  assign instr_ready  = !issue;
  assign dp_valid     = issue;
  assign dp_op        = issue ? op_q     : '0;
  assign dp_base      = issue ? base_q   : '0;
  assign dp_mask      = issue ? mask_raw : '0;
  assign dp_last      = issue && last_raw;
  assign vlen         = vlen_q;
  assign sca_op_valid = sca_valid_q;
  assign sca_op       = sca_op_q;
  assign err_illegal  = err_q;

`ifdef VSEQ_PERF_CNT_EN
  logic [31:0] beats_q;
  logic [31:0] stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (beat_hs && (beats_q != '1)) begin
        beats_q <= beats_q + 32'd1;
      end
      if (issue && !dp_ready && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign perf_beats  = beats_q;
  assign perf_stalls = stalls_q;
`else
  logic unused_hs;
  assign unused_hs   = beat_hs;
  assign perf_beats  = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vec_op_sequencer.sv
module tb_vec_op_sequencer;

  localparam logic [4:0] OP_INCRI = 5'b00000;
  localparam logic [4:0] OP_INCRJ = 5'b00010;
  localparam logic [4:0] OP_SETN  = 5'b00100;
  localparam logic [4:0] OP_SUMFV = 5'b00110;
  localparam logic [4:0] OP_MULFV = 5'b01001;
  localparam logic [4:0] OP_NOP   = 5'b01010;
  localparam logic [4:0] OP_LDV   = 5'b01101;
  localparam logic [4:0] OP_BAD   = 5'b11111;

`ifdef VSEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  opcode;
  logic [24:0] imm;
  logic        sca_op_valid;
  logic [1:0]  sca_op;
  logic        dp_valid;
  logic        dp_ready;
  logic [4:0]  dp_op;
  logic [24:0] dp_base;
  logic [3:0]  dp_mask;
  logic        dp_last;
  logic [24:0] vlen;
  logic        err_illegal;
  logic [31:0] perf_beats;
  logic [31:0] perf_stalls;

  vec_op_sequencer #(
    .LANES (4),
    .IMM_W (25),
    .OP_W  (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .imm          (imm),
    .sca_op_valid (sca_op_valid),
    .sca_op       (sca_op),
    .dp_valid     (dp_valid),
    .dp_ready     (dp_ready),
    .dp_op        (dp_op),
    .dp_base      (dp_base),
    .dp_mask      (dp_mask),
    .dp_last      (dp_last),
    .vlen         (vlen),
    .err_illegal  (err_illegal),
    .perf_beats   (perf_beats),
    .perf_stalls  (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_beats_cnt  = 0;
  int unsigned exp_stalls_cnt = 0;

  typedef struct {
    int unsigned vl;
    logic [4:0]  op;
    int unsigned stall;
    int unsigned beats;
    logic [3:0]  last_mask;
  } vec_rec_t;

  typedef struct {
    logic       valid;
    logic [4:0] op;
    logic       exp_sca_v;
    logic [1:0] exp_sca;
    logic       exp_err;
  } sca_rec_t;

  vec_rec_t vec_tab [6];
  sca_rec_t sca_tab [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] op, input logic [24:0] val);
    check("issue_ready", 64'(instr_ready), 64'd1);
    instr_valid = 1'b1;
    opcode      = op;
    imm         = val;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic check_perf();
    check("perf_beats",  64'(perf_beats),  PERF_EN ? 64'(exp_beats_cnt)  : 64'd0);
    check("perf_stalls", 64'(perf_stalls), PERF_EN ? 64'(exp_stalls_cnt) : 64'd0);
  endtask

  task automatic run_vec(input vec_rec_t r);
    logic [3:0] em;
    logic       el;
    issue(OP_SETN, 25'(r.vl));
    check("setn_vlen", 64'(vlen), 64'(r.vl));
    issue(r.op, 25'd0);
    // A pending SETN must not be taken while the vector op is streaming.
    instr_valid = 1'b1;
    opcode      = OP_SETN;
    imm         = 25'd12345;
    for (int unsigned b = 0; b < r.beats; b++) begin
      el = (b == r.beats - 1);
      em = el ? r.last_mask : 4'b1111;
      for (int unsigned s = 0; s < r.stall; s++) begin
        dp_ready = 1'b0;
        check("stall_valid", 64'(dp_valid), 64'd1);
        check("stall_base",  64'(dp_base),  64'(b * 4));
        check("stall_mask",  64'(dp_mask),  64'(em));
        check("stall_last",  64'(dp_last),  64'(el));
        check("stall_op",    64'(dp_op),    64'(r.op));
        step();
        exp_stalls_cnt++;
      end
      dp_ready = 1'b1;
      check("beat_valid", 64'(dp_valid),    64'd1);
      check("beat_ready", 64'(instr_ready), 64'd0);
      check("beat_op",    64'(dp_op),       64'(r.op));
      check("beat_base",  64'(dp_base),     64'(b * 4));
      check("beat_mask",  64'(dp_mask),     64'(em));
      check("beat_last",  64'(dp_last),     64'(el));
      if (el) instr_valid = 1'b0;
      step();
      exp_beats_cnt++;
    end
    dp_ready = 1'b0;
    check("done_valid", 64'(dp_valid),    64'd0);
    check("done_ready", 64'(instr_ready), 64'd1);
    check("done_base",  64'(dp_base),     64'd0);
    check("done_mask",  64'(dp_mask),     64'd0);
    check("done_last",  64'(dp_last),     64'd0);
    check("done_op",    64'(dp_op),       64'd0);
    check("done_vlen",  64'(vlen),        64'(r.vl));
    check_perf();
  endtask

  initial begin
    vec_tab[0] = '{vl: 400, op: OP_MULFV, stall: 0, beats: 100, last_mask: 4'b1111};
    vec_tab[1] = '{vl: 10,  op: OP_SUMFV, stall: 0, beats: 3,   last_mask: 4'b0011};
    vec_tab[2] = '{vl: 8,   op: OP_LDV,   stall: 3, beats: 2,   last_mask: 4'b1111};
    vec_tab[3] = '{vl: 5,   op: OP_MULFV, stall: 1, beats: 2,   last_mask: 4'b0001};
    vec_tab[4] = '{vl: 1,   op: OP_SUMFV, stall: 0, beats: 1,   last_mask: 4'b0001};
    vec_tab[5] = '{vl: 7,   op: OP_LDV,   stall: 2, beats: 2,   last_mask: 4'b0111};

    sca_tab[0] = '{valid: 1'b1, op: OP_LDV,   exp_sca_v: 1'b0, exp_sca: 2'b00, exp_err: 1'b0};
    sca_tab[1] = '{valid: 1'b1, op: OP_INCRI, exp_sca_v: 1'b1, exp_sca: 2'b01, exp_err: 1'b0};
    sca_tab[2] = '{valid: 1'b1, op: OP_INCRJ, exp_sca_v: 1'b1, exp_sca: 2'b10, exp_err: 1'b0};
    sca_tab[3] = '{valid: 1'b1, op: OP_NOP,   exp_sca_v: 1'b0, exp_sca: 2'b00, exp_err: 1'b0};
    sca_tab[4] = '{valid: 1'b1, op: OP_BAD,   exp_sca_v: 1'b0, exp_sca: 2'b00, exp_err: 1'b1};
    sca_tab[5] = '{valid: 1'b0, op: OP_NOP,   exp_sca_v: 1'b0, exp_sca: 2'b00, exp_err: 1'b0};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    imm         = '0;
    dp_ready    = 1'b0;

    // Reset state, then idle with no stimulus.
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready",  64'(instr_ready),  64'd1);
      check("rst_dpv",    64'(dp_valid),     64'd0);
      check("rst_vlen",   64'(vlen),         64'd0);
      check("rst_scav",   64'(sca_op_valid), 64'd0);
      check("rst_sca",    64'(sca_op),       64'd0);
      check("rst_err",    64'(err_illegal),  64'd0);
      check("rst_dpbase", 64'(dp_base),      64'd0);
      check("rst_dpmask", 64'(dp_mask),      64'd0);
      check("rst_dplast", 64'(dp_last),      64'd0);
      check("rst_dpop",   64'(dp_op),        64'd0);
      check_perf();
      if (i == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
      end
    end

    // vlen = 0, then back-to-back LDV, INCRI, INCRJ, NOP, illegal.
    issue(OP_SETN, 25'd0);
    for (int i = 0; i < 6; i++) begin
      instr_valid = sca_tab[i].valid;
      opcode      = sca_tab[i].op;
      imm         = 25'd0;
      step();
      check("seq_ready", 64'(instr_ready),  64'd1);
      check("seq_dpv",   64'(dp_valid),     64'd0);
      check("seq_scav",  64'(sca_op_valid), 64'(sca_tab[i].exp_sca_v));
      check("seq_sca",   64'(sca_op),       64'(sca_tab[i].exp_sca));
      check("seq_err",   64'(err_illegal),  64'(sca_tab[i].exp_err));
      check("seq_vlen",  64'(vlen),         64'd0);
    end
    instr_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vec_tab[i]);
    end

    // Reset in the middle of a long op.
    issue(OP_SETN, 25'd400);
    issue(OP_MULFV, 25'd0);
    dp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_beats_cnt++;
    end
    check("mid_base", 64'(dp_base),  64'd16);
    check("mid_dpv",  64'(dp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_beats_cnt  = 0;
    exp_stalls_cnt = 0;
    check("arst_dpv",   64'(dp_valid),    64'd0);
    check("arst_vlen",  64'(vlen),        64'd0);
    check("arst_ready", 64'(instr_ready), 64'd1);
    check("arst_base",  64'(dp_base),     64'd0);
    check_perf();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_dpv",   64'(dp_valid),    64'd0);
      check("post_ready", 64'(instr_ready), 64'd1);
    end
    dp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
